// File: rtl/pad_gpio_pkg.sv
// Shared types and defaults for the per-pin GPIO pad control stage.
// The pad_drive() helper maps one pin's output config onto pad DIN/OEN.
package pad_gpio_pkg;

  localparam int DefNumPads    = 8;
  localparam int DefSyncStages = 2;
  localparam int DefDebounceW  = 4;

  typedef enum logic {
    PadPushPull  = 1'b0,
    PadOpenDrain = 1'b1
  } pad_mode_e;

  typedef struct packed {
    logic      out_val;
    logic      out_en;
    pad_mode_e od_en;
    logic      irq_rise_en;
    logic      irq_fall_en;
  } pad_cfg_t;

  typedef struct packed {
    logic din;
    logic oen;
  } pad_drive_t;

  // Open-drain only ever pulls low; a requested '1' releases the pad instead.
  function automatic pad_drive_t pad_drive(pad_cfg_t cfg);
    pad_drive_t d;
    if (cfg.od_en == PadOpenDrain) begin
      d.din = 1'b0;
      d.oen = ~(cfg.out_en & ~cfg.out_val);
    end else begin
      d.din = cfg.out_val;
      d.oen = ~cfg.out_en;
    end
    return d;
  endfunction

endpackage

// File: rtl/pad_gpio_if.sv
// Register-file side of the GPIO pad controller: per-pin config in, status out.
// master = SoC GPIO register file, slave = pad_gpio_ctrl.
interface pad_gpio_if
  import pad_gpio_pkg::*;
#(
   parameter int NumPads   = DefNumPads,
   parameter int DebounceW = DefDebounceW
);

   logic [NumPads-1:0]   out_val;
   logic [NumPads-1:0]   out_en;
   logic [NumPads-1:0]   od_en;
   logic [DebounceW-1:0] db_cycles;
   logic [NumPads-1:0]   irq_rise_en;
   logic [NumPads-1:0]   irq_fall_en;
   logic [NumPads-1:0]   irq_clr;
   logic [NumPads-1:0]   in_val;
   logic [NumPads-1:0]   irq_pending;
   logic                 irq;

   modport master (
      output out_val, out_en, od_en, db_cycles, irq_rise_en, irq_fall_en, irq_clr,
      input  in_val, irq_pending, irq
   );

   modport slave (
      input  out_val, out_en, od_en, db_cycles, irq_rise_en, irq_fall_en, irq_clr,
      output in_val, irq_pending, irq
   );

endinterface

// File: rtl/pad_gpio_debounce.sv
// One pin's input path: synchronizer chain, debounce counter, debounced value
// and single-cycle rise/fall pulses coincident with the in_val update.
module pad_gpio_debounce
  import pad_gpio_pkg::*;
#(
   parameter int SyncStages = DefSyncStages,
   parameter int DebounceW  = DefDebounceW
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 pad_dout_i,
   input  logic [DebounceW-1:0] db_cycles_i,
   output logic                 in_val_o,
   output logic                 rise_o,
   output logic                 fall_o
);

   logic [SyncStages-1:0] sync_q;
   logic [DebounceW-1:0]  cnt_q;
   logic [DebounceW-1:0]  cnt_d;
   logic                  in_val_d;
   logic                  update;
   logic                  sync;

   assign sync = sync_q[SyncStages-1];

   // >= rather than == so lowering db_cycles below the running count still fires.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      cnt_d    = '0;
      in_val_d = in_val_o;
      update   = 1'b0;
      if (sync != in_val_o) begin
         if (cnt_q >= db_cycles_i) begin
            update   = 1'b1;
            in_val_d = sync;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign rise_o = update & sync;
   assign fall_o = update & ~sync;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         in_val_o <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SyncStages-2:0], pad_dout_i};
         cnt_q    <= cnt_d;
         in_val_o <= in_val_d;
      end
   end

endmodule

// File: rtl/pad_gpio_ctrl.sv
// Per-pin control stage in front of the bidirectional pad cells: registered
// push-pull/open-drain output drive, debounced input and sticky edge interrupts.
module pad_gpio_ctrl
  import pad_gpio_pkg::*;
#(
   parameter int NumPads    = DefNumPads,
   parameter int SyncStages = DefSyncStages,
   parameter int DebounceW  = DefDebounceW
) (
   input  logic               clk_i,
   input  logic               rst_i,
   pad_gpio_if.slave          bus,
   output logic [NumPads-1:0] pad_din_o,
   output logic [NumPads-1:0] pad_oen_o,
   input  logic [NumPads-1:0] pad_dout_i
);

   pad_cfg_t           cfg   [NumPads];
   pad_drive_t         drive [NumPads];
   logic [NumPads-1:0] din_d;
   logic [NumPads-1:0] oen_d;
   logic [NumPads-1:0] rise;
   logic [NumPads-1:0] fall;
   logic [NumPads-1:0] set;
   logic [NumPads-1:0] in_val;
   logic [NumPads-1:0] pend_q;

   for (genvar i = 0; i < NumPads; i++) begin : g_pin
      assign cfg[i] = '{
         out_val:     bus.out_val[i],
         out_en:      bus.out_en[i],
         od_en:       pad_mode_e'(bus.od_en[i]),
         irq_rise_en: bus.irq_rise_en[i],
         irq_fall_en: bus.irq_fall_en[i]
      };
      assign drive[i] = pad_drive(cfg[i]);
      assign din_d[i] = drive[i].din;
      assign oen_d[i] = drive[i].oen;
      assign set[i]   = (rise[i] & cfg[i].irq_rise_en) | (fall[i] & cfg[i].irq_fall_en);

      pad_gpio_debounce #(
         .SyncStages (SyncStages),
         .DebounceW  (DebounceW)
      ) u_debounce (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .pad_dout_i  (pad_dout_i[i]),
         .db_cycles_i (bus.db_cycles),
         .in_val_o    (in_val[i]),
         .rise_o      (rise[i]),
         .fall_o      (fall[i])
      );
   end

   // A new edge in the same cycle as a clear keeps the pin pending.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pad_din_o <= '0;
         pad_oen_o <= '1;
         pend_q    <= '0;
      end else begin
         pad_din_o <= din_d;
         pad_oen_o <= oen_d;
         pend_q    <= (pend_q & ~bus.irq_clr) | set;
      end
   end

   assign bus.in_val      = in_val;
   assign bus.irq_pending = pend_q;
   assign bus.irq         = |pend_q;

endmodule
